// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: single-outstanding PC fetch against a synchronous SRAM.
// Optional performance counters are enabled with `define IFETCH_PERF_EN.
module ifetch_responder #(
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [31:0]       rsp_pc,
  output logic              rsp_err,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_stall
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        fault;

  always_comb begin
    req_ready = 1'b0;
    if (reset_n && !flush) begin
      case (state_q)
        S_IDLE:  req_ready = 1'b1;
        S_RESP:  req_ready = rsp_ready;
        default: req_ready = 1'b0;
      endcase
    end
  end

  assign accept = req_valid && req_ready;
  assign fault  = (req_addr[1:0] != 2'b00) || ((req_addr >> (MEM_AW + 2)) != 32'd0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        instr_d = mem_rdata;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = state_q;
    endcase
    // Accept covers both IDLE and the back-to-back case out of RESP.
    if (accept) begin
      pc_d = req_addr;
      if (fault) begin
        state_d = S_RESP;
        err_d   = 1'b1;
        instr_d = NOP_INSTR;
      end else if (WAIT_CYCLES == 0) begin
        state_d = S_ISSUE;
      end else begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_CYCLES);
      end
    end
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_instr = instr_q;
  assign rsp_pc    = pc_q;
  assign rsp_err   = err_q;
  assign mem_en    = (state_q == S_ISSUE);
  assign mem_addr  = pc_q[MEM_AW+1:2];

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (accept) perf_fetch_d = perf_fetch_q + 32'd1;
    if (req_valid && !req_ready) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_fetch = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: two instances (WAIT_CYCLES=0 and 3) on shared stimulus.
module tb_ifetch_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_ready;

  logic        req_ready0, rsp_valid0, rsp_err0, mem_en0;
  logic [31:0] rsp_instr0, rsp_pc0, mem_rdata0, perf_fetch0, perf_stall0;
  logic [9:0]  mem_addr0;

  logic        req_ready3, rsp_valid3, rsp_err3, mem_en3;
  logic [31:0] rsp_instr3, rsp_pc3, mem_rdata3, perf_fetch3, perf_stall3;
  logic [9:0]  mem_addr3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_fetch, exp_stall;

  always #5 clk = ~clk;

  ifetch_responder #(.MEM_AW(10), .WAIT_CYCLES(0), .NOP_INSTR(32'h0000_0013)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr0), .rsp_pc(rsp_pc0), .rsp_err(rsp_err0), .mem_en(mem_en0),
    .mem_addr(mem_addr0), .mem_rdata(mem_rdata0), .perf_fetch(perf_fetch0),
    .perf_stall(perf_stall0)
  );

  ifetch_responder #(.MEM_AW(10), .WAIT_CYCLES(3), .NOP_INSTR(32'h0000_0013)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready3),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr3), .rsp_pc(rsp_pc3), .rsp_err(rsp_err3), .mem_en(mem_en3),
    .mem_addr(mem_addr3), .mem_rdata(mem_rdata3), .perf_fetch(perf_fetch3),
    .perf_stall(perf_stall3)
  );

  function automatic logic [31:0] rom(input logic [9:0] a);
    if (a == 10'd0) return 32'h0050_0093;
    return 32'hA000_0000 | {22'd0, a};
  endfunction

  // SRAM model: data valid only the cycle after mem_en, garbage otherwise.
  always @(posedge clk) begin
    mem_rdata0 <= mem_en0 ? rom(mem_addr0) : 32'hDEAD_BEEF;
    mem_rdata3 <= mem_en3 ? rom(mem_addr3) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    req_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset values, with a request pending to prove req_ready stays low.
    reset_n = 1'b0; req_valid = 1'b1; req_addr = 32'h0; flush = 1'b0; rsp_ready = 1'b1;
    #3;
    check("rst_rdy", {31'd0, req_ready0}, 32'd0);
    check("rst_rvalid", {31'd0, rsp_valid0}, 32'd0);
    check("rst_err", {31'd0, rsp_err0}, 32'd0);
    check("rst_men", {31'd0, mem_en0}, 32'd0);
    check("rst_instr", rsp_instr0, 32'd0);
    check("rst_pc", rsp_pc0, 32'd0);
    check("rst_maddr", {22'd0, mem_addr0}, 32'd0);

    // Zero wait states.
    do_reset();
    req_valid = 1'b1; req_addr = 32'h0; #1;
    check("t1_rdy", {31'd0, req_ready0}, 32'd1);
    cyc(); req_valid = 1'b0; #1;
    check("t1_men_c1", {31'd0, mem_en0}, 32'd1);
    check("t1_maddr", {22'd0, mem_addr0}, 32'd0);
    check("t1_rv_c1", {31'd0, rsp_valid0}, 32'd0);
    cyc(); #1;
    check("t1_men_c2", {31'd0, mem_en0}, 32'd0);
    check("t1_rv_c2", {31'd0, rsp_valid0}, 32'd0);
    cyc(); #1;
    check("t1_rv_c3", {31'd0, rsp_valid0}, 32'd1);
    check("t1_instr", rsp_instr0, 32'h0050_0093);
    check("t1_pc", rsp_pc0, 32'h0);
    check("t1_err", {31'd0, rsp_err0}, 32'd0);
    cyc(); #1;
    check("t1_rv_c4", {31'd0, rsp_valid0}, 32'd0);

    // Three wait states.
    do_reset();
    req_valid = 1'b1; req_addr = 32'h10; #1;
    check("t2_rdy", {31'd0, req_ready3}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      cyc(); req_valid = 1'b0; #1;
      check("t2_rdy_low", {31'd0, req_ready3}, 32'd0);
      check("t2_men", {31'd0, mem_en3}, (k == 4) ? 32'd1 : 32'd0);
      check("t2_rv_low", {31'd0, rsp_valid3}, 32'd0);
      if (k == 4) check("t2_maddr", {22'd0, mem_addr3}, 32'd4);
    end
    cyc(); #1;
    check("t2_rv_c6", {31'd0, rsp_valid3}, 32'd1);
    check("t2_instr", rsp_instr3, 32'hA000_0004);
    check("t2_pc", rsp_pc3, 32'h10);

    // Misaligned then out-of-range fault, back to back.
    do_reset();
    req_valid = 1'b1; req_addr = 32'h6; #1;
    cyc(); req_addr = 32'h1000; #1;
    check("t3_rv", {31'd0, rsp_valid0}, 32'd1);
    check("t3_err", {31'd0, rsp_err0}, 32'd1);
    check("t3_instr", rsp_instr0, 32'h0000_0013);
    check("t3_pc", rsp_pc0, 32'h6);
    check("t3_men", {31'd0, mem_en0}, 32'd0);
    check("t3_rdy", {31'd0, req_ready0}, 32'd1);
    cyc(); req_valid = 1'b0; #1;
    check("t3b_rv", {31'd0, rsp_valid0}, 32'd1);
    check("t3b_err", {31'd0, rsp_err0}, 32'd1);
    check("t3b_instr", rsp_instr0, 32'h0000_0013);
    check("t3b_pc", rsp_pc0, 32'h1000);
    check("t3b_men", {31'd0, mem_en0}, 32'd0);
    cyc(); #1;
    check("t3_idle", {31'd0, rsp_valid0}, 32'd0);

    // Backpressure in RESP, then same-cycle accept.
    do_reset();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h20; #1;
    cyc(); req_valid = 1'b0;
    cyc(); cyc();
    req_valid = 1'b1; req_addr = 32'h8;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_rv", {31'd0, rsp_valid0}, 32'd1);
      check("t4_instr", rsp_instr0, 32'hA000_0008);
      check("t4_pc", rsp_pc0, 32'h20);
      check("t4_err", {31'd0, rsp_err0}, 32'd0);
      check("t4_rdy", {31'd0, req_ready0}, 32'd0);
      cyc();
    end
    rsp_ready = 1'b1; #1;
    check("t4_acc_rdy", {31'd0, req_ready0}, 32'd1);
    cyc(); req_valid = 1'b0; #1;
    check("t4_men", {31'd0, mem_en0}, 32'd1);
    check("t4_maddr", {22'd0, mem_addr0}, 32'd2);

    // Flush during WAIT; request under flush is refused, then taken next cycle.
    do_reset();
    req_valid = 1'b1; req_addr = 32'h0; #1;
    cyc(); req_valid = 1'b0;
    cyc(); flush = 1'b1; req_valid = 1'b1; req_addr = 32'h10; #1;
    check("t5_flush_rdy", {31'd0, req_ready3}, 32'd0);
    cyc(); flush = 1'b0; #1;
    check("t5_rv_c3", {31'd0, rsp_valid3}, 32'd0);
    check("t5_rdy_c3", {31'd0, req_ready3}, 32'd1);
    for (int k = 4; k <= 8; k++) begin
      cyc(); req_valid = 1'b0; #1;
      check("t5_rv_low", {31'd0, rsp_valid3}, 32'd0);
    end
    cyc(); #1;
    check("t5_rv_c9", {31'd0, rsp_valid3}, 32'd1);
    check("t5_pc", rsp_pc3, 32'h10);
    check("t5_instr", rsp_instr3, 32'hA000_0004);

    // Flush during CAPTURE.
    do_reset();
    req_valid = 1'b1; req_addr = 32'h0; #1;
    cyc(); req_valid = 1'b0;
    cyc(); flush = 1'b1; #1;
    check("t6_flush_rdy", {31'd0, req_ready0}, 32'd0);
    cyc(); flush = 1'b0; #1;
    check("t6_rv_c3", {31'd0, rsp_valid0}, 32'd0);
    check("t6_rdy_c3", {31'd0, req_ready0}, 32'd1);
    cyc(); #1;
    check("t6_rv_c4", {31'd0, rsp_valid0}, 32'd0);

    // Four back-to-back fetches: accepts at cycles 0,3,6,9, six stall cycles.
    do_reset();
    for (int f = 0; f < 4; f++) begin
      req_valid = 1'b1; req_addr = 32'(f * 4); #1;
      if (f > 0) begin
        check("t7_rv", {31'd0, rsp_valid0}, 32'd1);
        check("t7_instr", rsp_instr0, rom(10'(f - 1)));
      end
      check("t7_rdy", {31'd0, req_ready0}, 32'd1);
      cyc();
      if (f == 3) req_valid = 1'b0;
      cyc(); cyc();
    end
    #1;
    check("t7_rv_last", {31'd0, rsp_valid0}, 32'd1);
    check("t7_instr_last", rsp_instr0, 32'hA000_0003);
    cyc(); #1;
`ifdef IFETCH_PERF_EN
    exp_fetch = 32'd4; exp_stall = 32'd6;
`else
    exp_fetch = 32'd0; exp_stall = 32'd0;
`endif
    check("t7_perf_fetch", perf_fetch0, exp_fetch);
    check("t7_perf_stall", perf_stall0, exp_stall);

    // Asynchronous reset while holding a response.
    do_reset();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h6; #1;
    cyc(); req_valid = 1'b0; #1;
    check("t8_rv_pre", {31'd0, rsp_valid0}, 32'd1);
    #1; reset_n = 1'b0; #1;
    check("t8_rv", {31'd0, rsp_valid0}, 32'd0);
    check("t8_err", {31'd0, rsp_err0}, 32'd0);
    check("t8_instr", rsp_instr0, 32'd0);
    check("t8_pc", rsp_pc0, 32'd0);
    check("t8_rdy", {31'd0, req_ready0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_responder.md
Name: ifetch_responder

Overview:
- Instruction-memory side of the fetch interface: accepts PC fetch requests, reads a synchronous instruction SRAM and returns the instruction word to the IF/ID stage.
- Sits between the program counter (requester) and the instruction SRAM.
- Drives req_ready, which the PC logic uses as its stall source.
- Supports configurable wait states, output backpressure, pipeline flush on jump/branch, and address-fault reporting.

Parameters:
- MEM_AW, 10, word-address width of the instruction SRAM (4 KiB default).
- WAIT_CYCLES, 0, extra SRAM wait states inserted before each read (0..15).
- NOP_INSTR, 32'h00000013, word returned on a faulting fetch (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  fetch request from PC logic
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_addr  in  32  byte address of the instruction (PC)
- flush  in  1  kill the in-flight fetch and any held response (j_br)
- rsp_valid  out  1  response valid to IF/ID
- rsp_ready  in  1  IF/ID can take the response
- rsp_instr  out  32  fetched instruction
- rsp_pc  out  32  address the response belongs to
- rsp_err  out  1  fetch fault (misaligned or out of range)
- mem_en  out  1  SRAM read enable, single-cycle pulse
- mem_addr  out  MEM_AW  SRAM word address, equal to req_addr[MEM_AW+1:2]
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - rsp_valid=0, rsp_err=0, mem_en=0.
  - rsp_instr=0, rsp_pc=0, mem_addr=0, wait counter=0.
  - req_ready=0 while reset_n is low.
- Single outstanding fetch. FSM states: IDLE, WAIT, ISSUE, CAPTURE, RESP.
- req_ready is combinational:
  - high in IDLE when flush=0;
  - high in RESP when rsp_ready=1 and flush=0;
  - low in all other states.
- Accept: when req_valid && req_ready, latch req_addr into the pc register.
- Fault check on the latched address: req_addr[1:0]!=0, or any bit of req_addr[31:MEM_AW+2] set.
  - On fault, next state is RESP with rsp_err=1 and rsp_instr=NOP_INSTR.
  - No SRAM access is made.
- Non-fault accept:
  - Next state is WAIT, with the counter loaded to WAIT_CYCLES.
  - If WAIT_CYCLES==0, go straight to ISSUE.
- WAIT: counter decrements each cycle; go to ISSUE on the cycle it reaches 0.
- ISSUE: mem_en=1 for exactly one cycle with mem_addr driven; next state is CAPTURE.
- CAPTURE: register mem_rdata into rsp_instr; rsp_err=0; next state is RESP.
- Latency: request accepted at edge T gives mem_en high in cycle T+1+WAIT_CYCLES and rsp_valid high in cycle T+3+WAIT_CYCLES.
- RESP:
  - rsp_valid=1; rsp_instr, rsp_pc and rsp_err stay stable until rsp_ready.
  - On rsp_ready with no new request, go to IDLE.
  - On rsp_ready with req_valid, this is a back-to-back accept: the new address is latched and the FSM goes to WAIT, ISSUE or RESP(fault) as above.
- Flush (highest priority):
  - In any state, flush=1 forces the next state to IDLE and rsp_valid to 0 at the next edge.
  - A discarded SRAM read is ignored; mem_en already issued is not retracted.
  - req_ready=0 during the flush cycle, so no request is accepted in that cycle.
- Reset asserted mid-operation: immediate return to the reset values; a pending response is lost.
- Stall: mem_rdata is sampled only in CAPTURE.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined: adds outputs perf_fetch[31:0] and perf_stall[31:0].
  - perf_fetch increments once per accepted request.
  - perf_stall increments on each cycle with req_valid && !req_ready.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports still exist, tied to 0, with no counter flops.

Test Plan:
- Reset, then req_addr=0x0000_0000 with WAIT_CYCLES=0 and mem_rdata=0x00500093 -> mem_en in cycle 1, mem_addr=0, rsp_valid in cycle 3 with rsp_instr=0x00500093, rsp_pc=0, rsp_err=0.
- WAIT_CYCLES=3, request 0x0000_0010 -> mem_en in cycle 4, mem_addr=4, rsp_valid in cycle 6; req_ready=0 in cycles 1-5.
- req_addr=0x0000_0006 -> no mem_en, rsp_valid next cycle with rsp_err=1 and rsp_instr=0x00000013; req_addr=0x0000_1000 (MEM_AW=10) gives the same result.
- Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable and req_ready=0; raise rsp_ready with req_valid at 0x0000_0008 -> same-cycle accept, next mem_addr=2.
- flush during WAIT and during CAPTURE -> IDLE next cycle, no rsp_valid; a request presented with flush=1 is not accepted, then accepted the following cycle.
- Assert reset_n low while in RESP -> rsp_valid falls immediately without a clock edge; with IFETCH_PERF_EN, 4 fetches give perf_fetch=4, and perf_stall equals the counted stall cycles.
